// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter between the CPU port (0) and the program loader (1)
// in front of a single-port memory. Each grant runs one fixed-latency memory
// access (IDLE -> ISSUE -> WAIT x MEM_LAT -> DONE) ending in a done pulse.
//
// Handshake: a port holds req high with a stable payload until it is granted.
// The payload is latched at the grant edge, and later req/payload changes are
// ignored. The access always completes and pulses that port's done for one
// cycle. If req is still high in the IDLE cycle after done, it is a new request.
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LAT_CNT = 4'(MEM_LAT);

  state_t            state_q, state_d;
  logic              last_owner_q, last_owner_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;

  logic any_req;
  logic grant_ldr;
  logic last_wait;

  // On a tie the port that did not win last time is granted.
  assign any_req   = cpu_req | ldr_req;
  assign grant_ldr = ldr_req & (~cpu_req | ~last_owner_q);
  assign last_wait = (state_q == S_WAIT) && (cnt_q == 4'd1);

  // State register; reset drops any access in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (cnt_q == 4'd1) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers: grant latches, latency counter, read-data holders.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= 4'd0;
      cpu_rdata_q  <= '0;
      ldr_rdata_q  <= '0;
    end else begin
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ldr_rdata_q  <= ldr_rdata_d;
    end
  end

  // Datapath next values: latch winner at grant, count WAIT, capture read data.
  always_comb begin
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    cpu_rdata_d  = cpu_rdata_q;
    ldr_rdata_d  = ldr_rdata_q;

    if ((state_q == S_IDLE) && any_req) begin
      owner_d      = grant_ldr;
      last_owner_d = grant_ldr;
      we_d         = grant_ldr ? ldr_we    : cpu_we;
      addr_d       = grant_ldr ? ldr_addr  : cpu_addr;
      wdata_d      = grant_ldr ? ldr_wdata : cpu_wdata;
    end

    if (state_q == S_ISSUE) cnt_d = LAT_CNT;
    else if (state_q == S_WAIT) cnt_d = cnt_q - 4'd1;

    if (last_wait && !we_q) begin
      if (owner_q) ldr_rdata_d = mem_rdata;
      else         cpu_rdata_d = mem_rdata;
    end
  end

  // Outputs decoded from the current state and the latched grant.
  always_comb begin
    mem_en    = (state_q == S_ISSUE);
    mem_we    = (state_q == S_ISSUE) && we_q;
    busy      = (state_q != S_IDLE);
    owner     = (state_q != S_IDLE) && owner_q;
    cpu_done  = (state_q == S_DONE) && !owner_q;
    ldr_done  = (state_q == S_DONE) && owner_q;
    dbg_state = state_q;
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ldr_rdata = ldr_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed transactions with a memory model,
// an issue/done scoreboard and directed cycle checks.
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int MEM_LAT = 2;

  // Clock/reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_done;
  logic              ldr_req = 1'b0, ldr_we = 1'b0;
  logic [ADDR_W-1:0] ldr_addr = '0;
  logic [DATA_W-1:0] ldr_wdata = '0;
  logic [DATA_W-1:0] ldr_rdata;
  logic              ldr_done;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy, owner;
  logic [1:0]        dbg_state;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata), .ldr_done(ldr_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner), .dbg_state(dbg_state)
  );

  // Memory model: read data is valid MEM_LAT cycles after the mem_en cycle.
  logic [DATA_W-1:0] mem [0:1023];
  logic [DATA_W-1:0] pend_data;
  int                pend_cnt;
  assign mem_rdata = (pend_cnt == 1) ? pend_data : 32'hBADBAD00;

  always @(posedge clock) begin
    if (reset) begin
      mem[10'h010] <= 32'hDEADBEEF;
      mem[10'h020] <= 32'h00000000;
      mem[10'h030] <= 32'hCAFEF00D;
      mem[10'h040] <= 32'h55AA55AA;
      mem[10'h050] <= 32'h01020304;
      mem[10'h060] <= 32'h0A0B0C0D;
      mem[10'h100] <= 32'h0BADF00D;
      mem[10'h200] <= 32'h00000000;
      pend_cnt     <= 0;
      pend_data    <= '0;
    end else begin
      if (mem_en && mem_we) mem[mem_addr[9:0]] <= mem_wdata;
      if (mem_en && !mem_we) begin
        pend_cnt  <= MEM_LAT;
        pend_data <= mem[mem_addr[9:0]];
      end else if (pend_cnt != 0) begin
        pend_cnt <= pend_cnt - 1;
      end
    end
  end

  // Scoreboard: issue entries {port, we, addr, wdata}, done entries {port, rdata}
  logic [49:0] iss_q[$];
  logic [32:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every memory issue and every done pulse against the queues
  always @(negedge clock) begin
    logic [49:0] ie;
    logic [32:0] de;
    if (!reset) begin
      if (mem_en) begin
        check("issue_expected", 64'(iss_q.size() != 0), 64'd1);
        if (iss_q.size() != 0) begin
          ie = iss_q.pop_front();
          check("issue_payload", 64'({owner, mem_we, mem_addr, mem_wdata}), 64'(ie));
        end
      end
      if (cpu_done && ldr_done) check("both_done", 64'd1, 64'd0);
      if (cpu_done || ldr_done) begin
        check("done_expected", 64'(exp_q.size() != 0), 64'd1);
        check("done_owner", 64'(owner), 64'(ldr_done));
        if (exp_q.size() != 0) begin
          de = exp_q.pop_front();
          check("done_port_rdata",
                64'({ldr_done, (ldr_done ? ldr_rdata : cpu_rdata)}), 64'(de));
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_drive(input logic req, input logic we, input logic [15:0] a,
                           input logic [31:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic ldr_drive(input logic req, input logic we, input logic [15:0] a,
                           input logic [31:0] d);
    ldr_req = req; ldr_we = we; ldr_addr = a; ldr_wdata = d;
  endtask

  task automatic wait_done(input logic port, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clock);
      if (port ? ldr_done : cpu_done) seen = 1'b1;
    end
    check(name, 64'(seen), 64'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int issues;
    int pulses;

    // Reset state
    #1;
    check("reset_state", 64'(dbg_state), 64'd0);
    check("reset_outputs", 64'({mem_en, mem_we, busy, owner, cpu_done, ldr_done}), 64'd0);
    check("reset_rdata", 64'({cpu_rdata, ldr_rdata}), 64'd0);
    check("reset_mem_bus", 64'({mem_addr, mem_wdata}), 64'd0);
    do_reset();

    // CPU read, latency profile
    tick();
    cpu_drive(1'b1, 1'b0, 16'h0010, 32'h11111111);
    iss_q.push_back({1'b0, 1'b0, 16'h0010, 32'h11111111});
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    @(negedge clock);
    check("rd_T_no_en", 64'(mem_en), 64'd0);
    tick();
    cpu_drive(1'b0, 1'b0, 16'h0000, 32'h0);
    @(negedge clock);
    check("rd_T1_en", 64'({mem_en, mem_we, mem_addr}), 64'({1'b1, 1'b0, 16'h0010}));
    tick();
    @(negedge clock);
    check("rd_T2_no_en", 64'(mem_en), 64'd0);
    check("rd_T2_busy", 64'(busy), 64'd1);
    tick();
    @(negedge clock);
    check("rd_T3_no_done", 64'(cpu_done), 64'd0);
    tick();
    @(negedge clock);
    check("rd_T4_done", 64'(cpu_done), 64'd1);
    check("rd_T4_rdata", 64'(cpu_rdata), 64'hDEADBEEF);
    tick();
    @(negedge clock);
    check("rd_T5_idle", 64'({busy, owner}), 64'd0);

    // Both requesting from reset: CPU, LDR, CPU
    do_reset();
    cpu_drive(1'b1, 1'b0, 16'h0100, 32'h0);
    ldr_drive(1'b1, 1'b1, 16'h0200, 32'hA5A5A5A5);
    iss_q.push_back({1'b0, 1'b0, 16'h0100, 32'h0});
    iss_q.push_back({1'b1, 1'b1, 16'h0200, 32'hA5A5A5A5});
    iss_q.push_back({1'b0, 1'b0, 16'h0100, 32'h0});
    exp_q.push_back({1'b0, 32'h0BADF00D});
    exp_q.push_back({1'b1, 32'h00000000});
    exp_q.push_back({1'b0, 32'h0BADF00D});
    issues = 0;
    for (int i = 0; i < 80 && issues < 3; i++) begin
      @(negedge clock);
      if (mem_en) issues++;
    end
    check("rr_issue_count", 64'(issues), 64'd3);
    tick();
    cpu_drive(1'b0, 1'b0, 16'h0, 32'h0);
    ldr_drive(1'b0, 1'b0, 16'h0, 32'h0);
    wait_done(1'b0, "rr_final_done");
    check("rr_mem_written", 64'(mem[10'h200]), 64'hA5A5A5A5);

    // Loader read then loader write; write leaves ldr_rdata alone
    tick();
    ldr_drive(1'b1, 1'b0, 16'h0030, 32'h0);
    iss_q.push_back({1'b1, 1'b0, 16'h0030, 32'h0});
    exp_q.push_back({1'b1, 32'hCAFEF00D});
    tick();
    ldr_drive(1'b0, 1'b0, 16'h0, 32'h0);
    wait_done(1'b1, "ldr_rd_done");
    tick();
    ldr_drive(1'b1, 1'b1, 16'h0020, 32'h12345678);
    iss_q.push_back({1'b1, 1'b1, 16'h0020, 32'h12345678});
    exp_q.push_back({1'b1, 32'hCAFEF00D});
    tick();
    ldr_drive(1'b0, 1'b0, 16'hFFFF, 32'hFFFFFFFF);
    @(negedge clock);
    check("wr_issue", 64'({mem_en, mem_we, mem_addr, mem_wdata}),
          64'({1'b1, 1'b1, 16'h0020, 32'h12345678}));
    tick();
    @(negedge clock);
    check("wr_single_en", 64'(mem_en), 64'd0);
    wait_done(1'b1, "ldr_wr_done");
    check("wr_rdata_kept", 64'(ldr_rdata), 64'hCAFEF00D);
    check("wr_mem", 64'(mem[10'h020]), 64'h12345678);

    // CPU drops req during WAIT; access completes, nothing new is issued
    tick();
    cpu_drive(1'b1, 1'b0, 16'h0040, 32'h0);
    iss_q.push_back({1'b0, 1'b0, 16'h0040, 32'h0});
    exp_q.push_back({1'b0, 32'h55AA55AA});
    tick();
    tick();
    cpu_drive(1'b0, 1'b0, 16'h0, 32'h0);
    wait_done(1'b0, "drop_done");
    tick();
    @(negedge clock);
    check("drop_idle1", 64'({busy, mem_en}), 64'd0);
    tick();
    @(negedge clock);
    check("drop_idle2", 64'({busy, mem_en}), 64'd0);

    // Loader raised during CPU WAIT waits for the CPU done
    tick();
    cpu_drive(1'b1, 1'b0, 16'h0050, 32'h0);
    iss_q.push_back({1'b0, 1'b0, 16'h0050, 32'h0});
    exp_q.push_back({1'b0, 32'h01020304});
    tick();
    cpu_drive(1'b0, 1'b0, 16'h0, 32'h0);
    tick();
    ldr_drive(1'b1, 1'b0, 16'h0060, 32'h0);
    iss_q.push_back({1'b1, 1'b0, 16'h0060, 32'h0});
    exp_q.push_back({1'b1, 32'h0A0B0C0D});
    pulses = 0;
    for (int i = 0; i < 20 && pulses == 0; i++) begin
      @(negedge clock);
      check("late_ldr_no_en", 64'(mem_en), 64'd0);
      if (cpu_done) pulses = 1;
    end
    check("late_cpu_done", 64'(pulses), 64'd1);
    tick();
    @(negedge clock);
    check("late_idle", 64'({busy, owner, mem_en}), 64'd0);
    tick();
    ldr_drive(1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge clock);
    check("late_ldr_issue", 64'({mem_en, owner}), 64'd3);
    wait_done(1'b1, "late_ldr_done");

    // Reset during WAIT drops the access
    tick();
    cpu_drive(1'b1, 1'b0, 16'h0010, 32'h0);
    iss_q.push_back({1'b0, 1'b0, 16'h0010, 32'h0});
    tick();
    cpu_drive(1'b0, 1'b0, 16'h0, 32'h0);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("abort_outputs", 64'({mem_en, busy, cpu_done, ldr_done}), 64'd0);
    check("abort_rdata", 64'({cpu_rdata, ldr_rdata}), 64'd0);
    tick();
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (cpu_done || ldr_done) pulses++;
    end
    check("abort_no_done", 64'(pulses), 64'd0);

    check("issue_queue_empty", 64'(iss_q.size()), 64'd0);
    check("done_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
